// File: rtl/cic_decimator.sv
// N-stage Hogenauer CIC decimator (differential delay 1): integrators at the input
// rate, decimate by R, N comb stages at the output rate, full-precision output.
module cic_decimator #(
  parameter int INPUT_WIDTH  = 2,
  parameter int N            = 6,
  parameter int R            = 256,
  parameter int OUTPUT_WIDTH = 50
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic signed [INPUT_WIDTH-1:0]  in_data,
  output logic                           out_valid,
  output logic signed [OUTPUT_WIDTH-1:0] out_data
);

  localparam int CNT_W     = $clog2(R);
  localparam int REG_WIDTH = INPUT_WIDTH + N * CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(R - 1);

  typedef logic signed [REG_WIDTH-1:0] reg_t;

  reg_t             integ [N];
  reg_t             d     [N];
  reg_t             x_in  [N];
  reg_t             comb_out;
  reg_t             in_ext;
  logic [CNT_W-1:0] cnt;
  logic             dec_stb;

  assign in_ext  = reg_t'(in_data);
  assign dec_stb = in_valid && (cnt == CNT_MAX);

  // Comb chain fed from the last integrator's value before this edge's update.
  always_comb begin
    reg_t acc;
    // NOTE: every variable written here gets a value before any branch or loop,
    // so no path leaves it holding its old value and no latch is inferred.
    acc = integ[N-1];
    for (int k = 0; k < N; k++) begin
      x_in[k] = acc;
      acc     = acc - d[k];
    end
    comb_out = acc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: these arrays are working registers, not RAM, so they are cleared on
      // reset; a stale comb delay would corrupt the output after a mid-run reset.
      for (int k = 0; k < N; k++) begin
        integ[k] <= '0;
        d[k]     <= '0;
      end
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      // NOTE: non-blocking updates mean integ[k-1] below is the pre-edge value,
      // which is exactly the pipelined-integrator behaviour we want.
      out_valid <= dec_stb;
      if (in_valid) begin
        integ[0] <= integ[0] + in_ext;
        for (int k = 1; k < N; k++) begin
          integ[k] <= integ[k] + integ[k-1];
        end
        cnt <= dec_stb ? '0 : cnt + 1'b1;
      end
      if (dec_stb) begin
        for (int k = 0; k < N; k++) begin
          d[k] <= x_in[k];
        end
        out_data <= OUTPUT_WIDTH'(comb_out);
      end
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// Bench for cic_decimator: three configurations share one stimulus stream and are
// compared every cycle against a prefix-sum / binomial-difference reference.
module tb_cic_decimator;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic signed [1:0] in_data;

  logic              a_valid, b_valid, c_valid;
  logic signed [7:0] a_data;
  logic signed [5:0] b_data;
  logic signed [49:0] c_data;

  always #5 clk = ~clk;

  cic_decimator #(.INPUT_WIDTH(2), .N(1), .R(4), .OUTPUT_WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(a_valid), .out_data(a_data));

  cic_decimator #(.INPUT_WIDTH(2), .N(2), .R(4), .OUTPUT_WIDTH(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(b_valid), .out_data(b_data));

  cic_decimator dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(c_valid), .out_data(c_data));

  // Per-configuration stages, decimation and register width.
  int pn[3] = '{1, 2, 6};
  int pr[3] = '{4, 4, 256};
  int pw[3] = '{4, 6, 50};

  int     hist[$];
  int     mcnt[3];
  logic   exp_valid[3];
  longint exp_data[3];
  longint outs_a[$], outs_b[$], outs_c[$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint obs, input longint expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Output for decimation at sample index i: the N-fold strictly-previous prefix
  // sum s of the accepted samples, differenced N times at lag R, wrapped to w bits.
  function automatic longint cic_ref(int n, int r, int w, int i);
    longint s[];
    longint acc, tmp, y, c;
    s = new[i + 1];
    for (int t = 0; t <= i; t++) s[t] = longint'(hist[t]);
    repeat (n) begin
      acc = 0;
      for (int t = 0; t <= i; t++) begin
        tmp  = s[t];
        s[t] = acc;
        acc  = acc + tmp;
      end
    end
    y = 0;
    c = 1;
    for (int k = 0; k <= n; k++) begin
      if (i - k * r >= 0) y = y + (((k % 2) == 1) ? -c : c) * s[i - k * r];
      c = c * (n - k) / (k + 1);
    end
    y = (y <<< (64 - w)) >>> (64 - w);
    return y;
  endfunction

  task automatic step(input logic rst_v, input logic v, input int din);
    logic   obs_v[3];
    longint obs_d[3];
    @(negedge clk);
    rst_n    = rst_v;
    in_valid = v;
    in_data  = 2'(din);
    @(posedge clk);
    #1;
    if (!rst_v) begin
      hist.delete();
      outs_a.delete();
      outs_b.delete();
      outs_c.delete();
      for (int j = 0; j < 3; j++) begin
        mcnt[j]      = 0;
        exp_valid[j] = 1'b0;
        exp_data[j]  = 0;
      end
    end else begin
      if (v) hist.push_back(din);
      for (int j = 0; j < 3; j++) begin
        exp_valid[j] = 1'b0;
        if (v) begin
          if (mcnt[j] == pr[j] - 1) begin
            mcnt[j]      = 0;
            exp_valid[j] = 1'b1;
            exp_data[j]  = cic_ref(pn[j], pr[j], pw[j], hist.size() - 1);
          end else begin
            mcnt[j]++;
          end
        end
      end
    end
    obs_v[0] = a_valid;  obs_d[0] = longint'(a_data);
    obs_v[1] = b_valid;  obs_d[1] = longint'(b_data);
    obs_v[2] = c_valid;  obs_d[2] = longint'(c_data);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("out_valid[dut%0d]", j), longint'(obs_v[j]), longint'(exp_valid[j]));
      check($sformatf("out_data[dut%0d]", j), obs_d[j], exp_data[j]);
    end
    if (a_valid === 1'b1) outs_a.push_back(obs_d[0]);
    if (b_valid === 1'b1) outs_b.push_back(obs_d[1]);
    if (c_valid === 1'b1) outs_c.push_back(obs_d[2]);
  endtask

  task automatic check_b_startup(input string tag);
    check({tag, "_count"}, longint'(outs_b.size() >= 3), 1);
    if (outs_b.size() >= 3) begin
      check({tag, "_b0"}, outs_b[0], 3);
      check({tag, "_b1"}, outs_b[1], 15);
      check({tag, "_b2"}, outs_b[2], 16);
    end
  endtask

  initial begin
    int base;
    longint lim;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset state.
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);

    // Constant +1 every cycle: N=1 gives 3,4,4; N=2 gives 3,15,16.
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1);
    check("t1_count", longint'(outs_a.size()), 10);
    if (outs_a.size() >= 3) begin
      check("t1_a0", outs_a[0], 3);
      check("t1_a1", outs_a[1], 4);
      check("t1_a2", outs_a[2], 4);
    end
    check_b_startup("t2");
    check("t2_steady", outs_b[$], 16);

    // One-cycle reset mid-frame with in_valid high, then restart.
    step(1'b1, 1'b1, 1);
    step(1'b1, 1'b1, 1);
    step(1'b0, 1'b1, 1);
    check("t6_zero_b", longint'(b_data), 0);
    check("t6_zero_c", longint'(c_data), 0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1);
    check_b_startup("t6");

    // +1 with random gaps in in_valid.
    step(1'b0, 1'b0, 0);
    for (int i = 0; i < 80; i++) step(1'b1, ($urandom_range(0, 2) != 0), 1);
    check_b_startup("t4");

    // Constant -2: REG_WIDTH minimum at steady state, integrators wrap.
    step(1'b0, 1'b0, 0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, -2);
    check("t3_b_steady", outs_b[$], -32);
    check("t3_a_steady", outs_a[$], -8);

    // Random samples and random gaps.
    step(1'b0, 1'b0, 0);
    for (int i = 0; i < 400; i++)
      step(1'b1, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)) - 2);

    // Default configuration: +1, then -1, then alternating.
    step(1'b0, 1'b0, 0);
    for (int i = 0; i < 8 * 256; i++) step(1'b1, 1'b1, 1);
    check("t5_pos_count", longint'(outs_c.size()), 8);
    check("t5_pos_steady", outs_c[$], 64'sd1 <<< 48);
    for (int i = 0; i < 8 * 256; i++) step(1'b1, 1'b1, -1);
    check("t5_neg_steady", outs_c[$], -(64'sd1 <<< 48));
    base = outs_c.size();
    for (int i = 0; i < 12 * 256; i++) step(1'b1, 1'b1, ((i % 2) == 0) ? 1 : -1);
    check("t5_alt_count", longint'(outs_c.size() - base), 12);
    lim = 64'sd1 <<< 40;
    for (int k = base + 7; k < outs_c.size(); k++)
      check($sformatf("t5_alt_bound[%0d]", k - base),
            longint'(outs_c[k] <= lim && outs_c[k] >= -lim), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
